// File: rtl/march_seq_ctrl.sv
// March C- memory test sequencer: six elements, 10N single-op cycles, registered memory strobes.
// Define MARCH_FAIL_LOG_EN to add first-miscompare capture ports (fail_addr, fail_elem, fail_data).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module march_seq_ctrl #(
  parameter int unsigned dw = `DATA_WIDTH,
  parameter int unsigned aw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [aw-1:0] mem_addr,
  output logic [dw-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [dw-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          fail
`ifdef MARCH_FAIL_LOG_EN
  ,
  output logic [aw-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [dw-1:0] fail_data
`endif
);

  localparam int unsigned EW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [aw-1:0]   addr_q, addr_d;
  logic            op_q, op_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic [dw-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            rd_vld_q, rd_vld_d;
  logic            rd_exp_q, rd_exp_d;

  logic            accept;
  logic            mismatch;
  logic            down;
  logic            last_op;
  logic            last_addr;
  logic            is_wr;

  // Counters (elem, addr, op) name the op on the bus; strobes are registered from their next values.
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    op_d     = op_q;
    fail_d   = fail_q;
    accept   = 1'b0;

    down      = (elem_q >= EW'(3));
    last_op   = (elem_q == EW'(0)) || (elem_q == EW'(5)) || op_q;
    last_addr = down ? (addr_q == '0) : (addr_q == '1);
    mismatch  = rd_vld_q && (mem_rdata != {dw{rd_exp_q}});

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
          elem_d  = '0;
          addr_d  = '0;
          op_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = down ? (addr_q - aw'(1)) : (addr_q + aw'(1));
          end else if (elem_q == EW'(5)) begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end else begin
            elem_d = elem_q + EW'(1);
            // M3..M5 walk downward, so entering M3 starts at the top address
            addr_d = (elem_q >= EW'(2)) ? '1 : '0;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      fail_d = 1'b0;
    end else if (mismatch) begin
      fail_d = 1'b1;
    end

    // Writes are M0's only op and the second op of M1..M4; everything else reads
    is_wr   = (elem_d == EW'(0)) || op_d;
    we_d    = (state_d == S_RUN) && is_wr;
    re_d    = (state_d == S_RUN) && !is_wr;
    wdata_d = (we_d && ((elem_d == EW'(1)) || (elem_d == EW'(3)))) ? '1 : '0;
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);

    rd_vld_d = re_q;
    rd_exp_d = re_q && ((elem_q == EW'(2)) || (elem_q == EW'(4)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      elem_q   <= '0;
      addr_q   <= '0;
      op_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_exp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      we_q     <= we_d;
      re_q     <= re_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      rd_vld_q <= rd_vld_d;
      rd_exp_q <= rd_exp_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

`ifdef MARCH_FAIL_LOG_EN
  logic [aw-1:0] rd_addr_q;
  logic [EW-1:0] rd_elem_q;
  logic [aw-1:0] fail_addr_q, fail_addr_d;
  logic [EW-1:0] fail_elem_q, fail_elem_d;
  logic [dw-1:0] fail_data_q, fail_data_d;

  // Only the first miscompare of a run is logged; later ones leave the record untouched
  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    if (accept) begin
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_data_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = rd_addr_q;
      fail_elem_d = rd_elem_q;
      fail_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else begin
      rd_addr_q   <= addr_q;
      rd_elem_q   <= elem_q;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;
`endif

endmodule
